// File: rtl/ntt_bram_sched.sv
// rtl/ntt_bram_sched.sv - in-place radix-2 NTT stage scheduler for a 1W/1R BRAM and a fixed-latency BFU
// Issues one operand read per cycle, delays the read address to form the write-back address.
module ntt_bram_sched #(
  parameter int LOG_N   = 12,
  parameter int BFU_LAT = 4,
  parameter int DW      = 36
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             host_wr_en,
  input  logic [LOG_N-1:0] host_addr,
  input  logic [DW-1:0]    host_din,
  input  logic [DW-1:0]    bfu_dout,
  output logic             bfu_op_valid,
  output logic             bfu_op_sel,
  output logic [LOG_N-2:0] bfu_tw_idx,
  output logic             bram_wr_en,
  output logic [LOG_N-1:0] bram_wr_addr,
  output logic [LOG_N-1:0] bram_rd_addr,
  output logic [DW-1:0]    bram_wr_din
);

  localparam int SW  = $clog2(LOG_N + 1);
  localparam int DL  = 1 + BFU_LAT;
  localparam int DCW = $clog2(DL);
  localparam logic [SW-1:0] LAST_STAGE = SW'(LOG_N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e           state_q;
  logic [SW-1:0]    s_q;
  logic [LOG_N-1:0] c_q;
  logic [DCW-1:0]   drain_q;
  logic             busy_q;
  logic             done_q;

  logic             op_valid_q;
  logic             op_sel_q;
  logic [LOG_N-2:0] op_tw_q;
  logic [DL-1:0]    dl_vld_q;
  logic [LOG_N-1:0] dl_addr_q [DL];

  logic [LOG_N-1:0] j_idx;
  logic [LOG_N-1:0] half;
  logic [LOG_N-1:0] k_idx;
  logic [LOG_N-1:0] a_addr;
  logic [LOG_N-1:0] b_addr;
  logic [LOG_N-1:0] issue_addr;
  logic [LOG_N-2:0] tw;
  logic             issue;
  logic             idle;

  // Butterfly j of stage s pairs a and a+half; even c reads a, odd c reads b.
  always_comb begin
    j_idx      = c_q >> 1;
    half       = LOG_N'(1) << s_q;
    k_idx      = j_idx & (half - LOG_N'(1));
    a_addr     = ((j_idx >> s_q) << (s_q + SW'(1))) + k_idx;
    b_addr     = a_addr + half;
    tw         = k_idx[LOG_N-2:0] << (LAST_STAGE - s_q);
    issue_addr = c_q[0] ? b_addr : a_addr;
  end

  assign issue = (state_q == RUN);
  assign idle  = (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            s_q     <= '0;
            c_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          c_q <= c_q + LOG_N'(1);
          if (&c_q) begin
            state_q <= DRAIN;
            drain_q <= DCW'(BFU_LAT);
          end
        end
        DRAIN: begin
          // Drain until the last write of this stage has landed before re-reading.
          if (drain_q == '0) begin
            if (s_q == LAST_STAGE) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              s_q     <= '0;
            end else begin
              state_q <= RUN;
              s_q     <= s_q + SW'(1);
            end
          end else begin
            drain_q <= drain_q - DCW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_q <= 1'b0;
      op_sel_q   <= 1'b0;
      op_tw_q    <= '0;
      dl_vld_q   <= '0;
      for (int i = 0; i < DL; i++) dl_addr_q[i] <= '0;
    end else begin
      op_valid_q   <= issue;
      op_sel_q     <= issue & c_q[0];
      op_tw_q      <= issue ? tw : '0;
      dl_vld_q     <= {dl_vld_q[DL-2:0], issue};
      dl_addr_q[0] <= issue_addr;
      for (int i = 1; i < DL; i++) dl_addr_q[i] <= dl_addr_q[i-1];
    end
  end

  // Host owns the BRAM ports only while idle.
  always_comb begin
    bram_wr_en   = idle ? host_wr_en : dl_vld_q[DL-1];
    bram_wr_addr = idle ? host_addr  : dl_addr_q[DL-1];
    bram_rd_addr = idle ? host_addr  : issue_addr;
    bram_wr_din  = idle ? host_din   : bfu_dout;
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign bfu_op_valid = op_valid_q;
  assign bfu_op_sel   = op_sel_q;
  assign bfu_tw_idx   = op_tw_q;

endmodule

// File: tb/tb_ntt_bram_sched.sv
// tb/tb_ntt_bram_sched.sv - bench for ntt_bram_sched with BRAM/BFU models and a golden NTT-order model
module tb_ntt_bram_sched;

  localparam int LOG_N   = 3;
  localparam int N       = 8;
  localparam int BFU_LAT = 2;
  localparam int DW      = 36;
  localparam int SCYC    = N + 1 + BFU_LAT;
  localparam int TOTAL   = LOG_N * SCYC + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             busy, done;
  logic             host_wr_en = 1'b0;
  logic [LOG_N-1:0] host_addr = '0;
  logic [DW-1:0]    host_din = '0;
  logic [DW-1:0]    bfu_dout;
  logic             bfu_op_valid, bfu_op_sel;
  logic [LOG_N-2:0] bfu_tw_idx;
  logic             bram_wr_en;
  logic [LOG_N-1:0] bram_wr_addr, bram_rd_addr;
  logic [DW-1:0]    bram_wr_din;

  ntt_bram_sched #(.LOG_N(LOG_N), .BFU_LAT(BFU_LAT), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .host_wr_en(host_wr_en), .host_addr(host_addr), .host_din(host_din),
    .bfu_dout(bfu_dout), .bfu_op_valid(bfu_op_valid), .bfu_op_sel(bfu_op_sel),
    .bfu_tw_idx(bfu_tw_idx), .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr),
    .bram_rd_addr(bram_rd_addr), .bram_wr_din(bram_wr_din)
  );

  function automatic logic [DW-1:0] bfu_f(input logic [DW-1:0] x, input logic [1:0] t, input logic sel);
    return (x * 36'd3) + ({34'd0, t} << 1) + {35'd0, sel} + 36'd1;
  endfunction

  // BRAM: one write port, registered read address
  logic [DW-1:0] mem [N];
  logic [DW-1:0] rd_dout;
  always @(posedge clk) begin
    if (bram_wr_en) mem[bram_wr_addr] <= bram_wr_din;
    rd_dout <= mem[bram_rd_addr];
  end

  // BFU: per-operand function with BFU_LAT cycles of latency
  logic [DW-1:0] pipe [BFU_LAT];
  always @(posedge clk) begin
    pipe[0] <= bfu_op_valid ? bfu_f(rd_dout, bfu_tw_idx, bfu_op_sel) : '0;
    for (int i = 1; i < BFU_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bfu_dout = pipe[BFU_LAT-1];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0]    gold [N];
  logic [LOG_N-1:0] e_rd [40];
  logic [LOG_N-1:0] e_wa [40];
  logic [1:0]       e_tw [40];
  bit               e_iss [40];
  bit               e_vld [40];
  bit               e_sel [40];
  bit               e_wen [40];

  task automatic host_load();
    logic [63:0] r;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      r = {$urandom, $urandom};
      host_wr_en = 1'b1;
      host_addr  = 3'(i);
      host_din   = r[DW-1:0];
      gold[i]    = r[DW-1:0];
      #1;
      chk("host_wr_en", 64'(bram_wr_en), 64'd1);
      chk("host_wr_addr", 64'(bram_wr_addr), 64'(i));
      chk("host_wr_din", 64'(bram_wr_din), 64'(r[DW-1:0]));
      chk("host_rd_addr", 64'(bram_rd_addr), 64'(i));
    end
    @(negedge clk);
    host_wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Expected per-cycle schedule and golden transform, built in natural NTT loop order
    for (int t = 0; t < 40; t++) begin
      e_rd[t] = '0; e_wa[t] = '0; e_tw[t] = '0;
      e_iss[t] = 0; e_vld[t] = 0; e_sel[t] = 0; e_wen[t] = 0;
    end
    for (int s = 0; s < LOG_N; s++) begin
      int t, h;
      t = s * SCYC;
      h = 1 << s;
      for (int st = 0; st < N; st += 2 * h)
        for (int k = 0; k < h; k++)
          for (int p = 0; p < 2; p++) begin
            e_iss[t] = 1;               e_rd[t] = 3'(st + k + p * h);
            e_vld[t+1] = 1;             e_sel[t+1] = (p == 1);
            e_tw[t+1] = 2'(k * (N / 2 / h));
            e_wen[t+1+BFU_LAT] = 1;     e_wa[t+1+BFU_LAT] = 3'(st + k + p * h);
            t++;
          end
    end

    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_op_valid", 64'(bfu_op_valid), 64'd0);
    chk("rst_op_sel", 64'(bfu_op_sel), 64'd0);
    chk("rst_tw", 64'(bfu_tw_idx), 64'd0);
    chk("rst_wr_en", 64'(bram_wr_en), 64'd0);
    rst_n = 1'b1;

    host_load();

    // Abort mid stage 1 (c=5) with a write-back about to land
    @(negedge clk);
    start = 1'b1;
    #1;
    chk("pre_busy", 64'(busy), 64'd0);
    for (int cyc = 0; cyc <= SCYC + 5; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd1);
      if (e_iss[cyc]) chk("abort_rd_addr", 64'(bram_rd_addr), 64'(e_rd[cyc]));
    end
    rst_n = 1'b0;
    #1;
    chk("abort_wr_en", 64'(bram_wr_en), 64'd0);
    chk("abort_busy_low", 64'(busy), 64'd0);
    chk("abort_op_valid", 64'(bfu_op_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("abort_wr_en_next", 64'(bram_wr_en), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("post_abort_wr_en", 64'(bram_wr_en), 64'd0);
      chk("post_abort_busy", 64'(busy), 64'd0);
    end

    host_load();
    for (int s = 0; s < LOG_N; s++) begin
      int h;
      h = 1 << s;
      for (int st = 0; st < N; st += 2 * h)
        for (int k = 0; k < h; k++)
          for (int p = 0; p < 2; p++)
            gold[st + k + p * h] = bfu_f(gold[st + k + p * h], 2'(k * (N / 2 / h)), p == 1);
    end

    // Full transform with stray start pulses and a host write during busy
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      logic [63:0] r;
      @(negedge clk);
      r = {$urandom, $urandom};
      start      = (cyc == 5 || cyc == TOTAL - 1);
      host_wr_en = (cyc == 12);
      host_addr  = 3'($urandom);
      host_din   = r[DW-1:0];
      #1;
      chk("busy", 64'(busy), 64'(cyc < TOTAL));
      chk("done", 64'(done), 64'(cyc == TOTAL - 1));
      if (cyc < TOTAL) begin
        chk("wr_en", 64'(bram_wr_en), 64'(e_wen[cyc]));
        if (e_wen[cyc]) chk("wr_addr", 64'(bram_wr_addr), 64'(e_wa[cyc]));
        chk("op_valid", 64'(bfu_op_valid), 64'(e_vld[cyc]));
        if (e_vld[cyc]) begin
          chk("op_sel", 64'(bfu_op_sel), 64'(e_sel[cyc]));
          chk("tw_idx", 64'(bfu_tw_idx), 64'(e_tw[cyc]));
        end
        if (e_iss[cyc]) chk("rd_addr", 64'(bram_rd_addr), 64'(e_rd[cyc]));
      end
    end
    start = 1'b0;

    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      host_addr = 3'(i);
      #1;
      chk("rb_rd_addr", 64'(bram_rd_addr), 64'(i));
      @(posedge clk);
      #1;
      chk("final_mem", 64'(rd_dout), 64'(gold[i]));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ntt_bram_sched.md
Name: ntt_bram_sched

Overview:
- In-place radix-2 NTT stage scheduler for the 36-bit x 4096-word dual-address BRAM (one write port, one registered-address read port).
- Generates butterfly read addresses, operand-valid/select strobes and twiddle indices for the butterfly unit (BFU), plus the delayed write-back addresses.
- While idle, gives a host load/unload path direct ownership of the BRAM ports.
- Sits between the top-level NTT FSM and the BRAM/BFU pair.

Parameters:
- LOG_N, 12, log2 of transform size N; BRAM address width equals LOG_N.
- BFU_LAT, 4, fixed BFU latency in cycles (>=1), operand-in to result-out.
- DW, 36, word width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run a full transform; honoured only in IDLE.
- busy  out  1  high in RUN/DRAIN/DONE.
- done  out  1  one-cycle pulse when the last stage has written back.
- host_wr_en  in  1  host write strobe, used only in IDLE.
- host_addr  in  LOG_N  host read/write address, used only in IDLE.
- host_din  in  DW  host write data.
- bfu_dout  in  DW  BFU result word.
- bfu_op_valid  out  1  BRAM rd_dout holds a BFU operand this cycle.
- bfu_op_sel  out  1  0 = operand a (lower index), 1 = operand b.
- bfu_tw_idx  out  LOG_N-1  twiddle index for the current operand, aligned with bfu_op_valid.
- bram_wr_en  out  1  to BRAM wr_en.
- bram_wr_addr  out  LOG_N  to BRAM wr_addr.
- bram_rd_addr  out  LOG_N  to BRAM rd_addr.
- bram_wr_din  out  DW  to BRAM wr_din.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; stage s=0; issue counter c=0; write-back delay line cleared.
  - busy=0, done=0, bfu_op_valid=0, bfu_op_sel=0, bfu_tw_idx=0, bram_wr_en=0.
- IDLE port mux (combinational):
  - bram_wr_en=host_wr_en, bram_wr_addr=host_addr, bram_rd_addr=host_addr, bram_wr_din=host_din.
- Non-IDLE port mux:
  - bram_wr_din=bfu_dout.
  - Host inputs are ignored; host writes during busy are dropped.
- Address generation (combinational from s, c):
  - j=c>>1, half=1<<s, k=j&(half-1).
  - a=((j>>s)<<(s+1))+k; b=a+half.
  - tw=k<<(LOG_N-1-s).
  - bram_rd_addr = a when c is even, b when c is odd.
- FSM states IDLE, RUN, DRAIN, DONE:
  - IDLE->RUN on start=1: s=0, c=0.
  - RUN: issue one read per cycle, c=0..N-1. After the c=N-1 issue, go to DRAIN with a drain count of 1+BFU_LAT.
  - DRAIN: lasts exactly 1+BFU_LAT cycles, with no reads issued.
    - At the end, if s=LOG_N-1, go to DONE; else s<=s+1, c<=0, go to RUN.
    - Draining removes the read-after-write hazard between stages.
  - DONE: exactly one cycle, done=1, then IDLE.
- Operand strobes (registered, one cycle after issue, aligned with BRAM rd_dout):
  - bfu_op_valid=1, bfu_op_sel=c[0] of the issue, bfu_tw_idx=tw of the issue.
- Write-back:
  - A delay line of depth 1+BFU_LAT carries {valid, issued address}.
  - bram_wr_en/bram_wr_addr come from its output, so the write for a read issued in cycle t lands in cycle t+1+BFU_LAT.
  - Write order equals read order (a then b).
- Timing:
  - Total non-IDLE cycles per transform = LOG_N*(N+1+BFU_LAT)+1.
  - Throughput: 1 read + 1 write per cycle; read and write addresses never collide within a stage.
- Boundary behaviour:
  - start while busy is ignored, with no restart.
  - start in the same cycle as DONE is ignored; it is accepted next cycle once in IDLE.
  - rst_n low mid-transform aborts immediately; in-flight writes are discarded with no partial write after reset.
  - BRAM contents are not touched by reset.

Test Plan (LOG_N=3, BFU_LAT=2):
- Reset mid-RUN (c=5, s=1) -> next cycle bram_wr_en=0, busy=0, bfu_op_valid=0; a subsequent start runs a full stage 0.
- Stage 0 after start -> bram_rd_addr 0,1,2,3,4,5,6,7 on consecutive cycles; bfu_tw_idx all 0; bfu_op_sel 0,1,0,1,...
- Stage 1 -> rd addrs 0,2,1,3,4,6,5,7; tw 0,0,2,2,0,0,2,2.
- Stage 2 -> rd addrs 0,4,1,5,2,6,3,7; tw 0,0,1,1,2,2,3,3.
- Write-back: BFU returns address-tagged data -> each bram_wr_en occurs exactly 3 cycles after its read; wr_addr equals the read address.
  - No write is issued in the first read cycle of stages 1 and 2.
  - Final BRAM matches the golden model.
- Timing/host: busy high for 34 cycles with done only on the 34th; start pulses at cycles 5 and 33 are ignored; host_wr_en during busy writes nothing; host writes/reads in IDLE pass straight through.
